// File: rtl/pc_sequencer_if.sv
// Handshake and datapath bundle between pc_sequencer and the MIPS datapath / instruction memory.
// The trap output exists only when PC_SEQ_ALIGN_TRAP_EN is defined.
interface pc_sequencer_if;
  logic        imem_req;
  logic        imem_ack;
  logic        dec_valid;
  logic        is_branch;
  logic        is_jump;
  logic        alu_zero;
  logic [31:0] branch_target;
  logic [31:0] jump_address;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        sel_pcsrc;
  logic        sel_jump;
  logic        ir_write;
  logic        pc_write;
  logic        fetch_err;
`ifdef PC_SEQ_ALIGN_TRAP_EN
  logic        trap;
`endif

  modport master (
`ifdef PC_SEQ_ALIGN_TRAP_EN
    output trap,
`endif
    output imem_req, pc, pc_plus4, sel_pcsrc, sel_jump, ir_write, pc_write, fetch_err,
    input  imem_ack, dec_valid, is_branch, is_jump, alu_zero, branch_target, jump_address, stall
  );

  modport slave (
`ifdef PC_SEQ_ALIGN_TRAP_EN
    input  trap,
`endif
    input  imem_req, pc, pc_plus4, sel_pcsrc, sel_jump, ir_write, pc_write, fetch_err,
    output imem_ack, dec_valid, is_branch, is_jump, alu_zero, branch_target, jump_address, stall
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multicycle MIPS PC controller: fetch (with timeout/retry), decode capture, PC update.
// Optional macro PC_SEQ_ALIGN_TRAP_EN redirects misaligned targets to TRAP_VECTOR.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MAX_WAIT    = 8
`ifdef PC_SEQ_ALIGN_TRAP_EN
  ,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {S_FETCH, S_RETRY, S_DECODE, S_UPDATE} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] pc_q;
  logic        req_q;
  logic        sel_pcsrc_q;
  logic        sel_jump_q;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic        fetch_live;
  logic        misaligned;

  // Right after reset the FSM sits in S_FETCH with the request still low,
  // so fetch handshakes are only honoured once req_q is up.
  assign fetch_live = (state == S_FETCH) && req_q;
  assign pc_plus4   = pc_q + 32'd4;

  always_comb begin
    target = pc_plus4;
    if (sel_jump_q)
      target = bus.jump_address;
    else if (sel_pcsrc_q)
      target = bus.branch_target;
  end

  assign misaligned = |target[1:0];

`ifdef PC_SEQ_ALIGN_TRAP_EN
  assign next_pc  = misaligned ? TRAP_VECTOR : target;
  assign bus.trap = bus.pc_write & misaligned;
`else
  assign next_pc  = target & ~32'h3;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      wait_cnt    <= '0;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      sel_pcsrc_q <= 1'b0;
      sel_jump_q  <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (bus.imem_ack) begin
            state    <= S_DECODE;
            wait_cnt <= '0;
            req_q    <= 1'b0;
          end else if (wait_cnt == LAST_WAIT) begin
            state    <= S_RETRY;
            wait_cnt <= '0;
            req_q    <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_RETRY: begin
          state <= S_FETCH;
          req_q <= 1'b1;
        end
        S_DECODE: begin
          if (bus.dec_valid) begin
            sel_jump_q  <= bus.is_jump;
            sel_pcsrc_q <= bus.is_branch & bus.alu_zero & ~bus.is_jump;
            state       <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (!bus.stall) begin
            pc_q  <= next_pc;
            state <= S_FETCH;
            req_q <= 1'b1;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.sel_pcsrc = sel_pcsrc_q;
  assign bus.sel_jump  = sel_jump_q;
  assign bus.ir_write  = fetch_live & bus.imem_ack;
  assign bus.fetch_err = fetch_live & ~bus.imem_ack & (wait_cnt == LAST_WAIT);
  assign bus.pc_write  = (state == S_UPDATE) & ~bus.stall;

endmodule
